// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the AXI4 SRAM controller.
package sram_ctrl_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR, WRESP, RD} arb_state_e;
endpackage

// File: rtl/axi_burst_addr.sv
// Beat address generator for one AXI4 burst: FIXED, INCR and WRAP sequencing.
module axi_burst_addr
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  input  logic                  load,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  logic [ADDR_WIDTH-1:0] addr_q, step, wrap_mask, addr_inc, addr_nxt;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q;
  burst_t                burst_q;

  // NOTE: every always_comb output gets a default or a full case so no latch is inferred.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = (ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q) - ADDR_WIDTH'(1);
    addr_inc  = addr_q + step;
    case (burst_q)
      FIXED:   addr_nxt = addr_q;
      WRAP:    addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_nxt = addr_inc;  // the reserved encoding sequences like INCR
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= FIXED;
    end else if (load) begin
      addr_q  <= start_addr;
      len_q   <= len;
      size_q  <= size;
      burst_q <= burst_t'(burst);
      beat_q  <= '0;
    end else if (advance) begin
      addr_q  <= addr_nxt;
      beat_q  <= beat_q + 8'd1;
    end
  end

  assign addr = addr_q;
  assign last = (beat_q == len_q);
endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; output is read from storage, push and pop may coincide.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
endmodule

// File: rtl/axi4_sram_ctrl_v2.sv
// AXI4 slave bridging a single-port synchronous SRAM, with credit-guarded read return
// and burst-granular round-robin arbitration between reads and writes.
module axi4_sram_ctrl_v2
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LAT     = 1
) (
  input  logic                         aclk_i,
  input  logic                         aresetn_i,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  output logic                         sram_cen_n_o,
  output logic                         sram_wen_n_o,
  output logic [DATA_WIDTH/8-1:0]      sram_bm_n_o,
  output logic [$clog2(MEM_DEPTH)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]        sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]        sram_rdata_i
);
  localparam int OFFS        = $clog2(DATA_WIDTH / 8);
  localparam int MAW         = $clog2(MEM_DEPTH);
  localparam int RFIFO_DEPTH = RD_LAT + 2;
  localparam int CRW         = $clog2(RFIFO_DEPTH + 1);

  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
    logic                last;
    logic                err;
  } rd_meta_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_beat_t;

  arb_state_e            state_q, state_d;
  logic                  rr_q;  // 1: read wins the next simultaneous request
  logic [ID_WIDTH-1:0]   bid_q, rid_q;
  logic                  wr_err_q;
  logic [CRW-1:0]        credit_q;
  rd_meta_t [RD_LAT-1:0] pipe_q;
  rd_meta_t              pipe_out;
  r_beat_t               push_beat, pop_beat, r_out;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, wr_word, rd_word;
  logic                  wr_oor, rd_oor, rd_last, wr_last_unused, fifo_empty;
  logic                  grant_wr, grant_rd, w_hs, r_hs, rd_issue;

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .clk(aclk_i), .rst_n(aresetn_i), .start_addr(awaddr), .len(awlen), .size(awsize),
    .burst(awburst), .load(grant_wr), .advance(w_hs), .addr(wr_addr), .last(wr_last_unused)
  );

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .clk(aclk_i), .rst_n(aresetn_i), .start_addr(araddr), .len(arlen), .size(arsize),
    .burst(arburst), .load(grant_rd), .advance(rd_issue), .addr(rd_addr), .last(rd_last)
  );

  assign wr_word  = wr_addr >> OFFS;
  assign rd_word  = rd_addr >> OFFS;
  assign wr_oor   = (wr_word >= ADDR_WIDTH'(MEM_DEPTH));
  assign rd_oor   = (rd_word >= ADDR_WIDTH'(MEM_DEPTH));
  assign grant_wr = (state_q == IDLE) && awvalid && (!arvalid || !rr_q);
  assign grant_rd = (state_q == IDLE) && arvalid && (!awvalid || rr_q);
  assign w_hs     = (state_q == WR) && wvalid;
  assign r_hs     = rvalid && rready;
  // A pop in the same cycle frees the slot this issue will eventually occupy.
  assign rd_issue = (state_q == RD) && ((credit_q < CRW'(RFIFO_DEPTH)) || r_hs);

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_wr) state_d = WR; else if (grant_rd) state_d = RD;
      WR:      if (w_hs && wlast) state_d = WRESP;
      WRESP:   if (bready) state_d = IDLE;
      RD:      if (rd_issue && rd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awready      = 1'b0;
    arready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    sram_cen_n_o = 1'b1;
    sram_wen_n_o = 1'b1;
    sram_bm_n_o  = '1;
    sram_addr_o  = MAW'(rd_word);
    case (state_q)
      IDLE: begin
        awready = grant_wr;
        arready = grant_rd;
      end
      WR: begin
        wready      = 1'b1;
        sram_addr_o = MAW'(wr_word);
        if (wvalid) begin
          sram_cen_n_o = wr_oor;
          sram_wen_n_o = 1'b0;
          sram_bm_n_o  = ~wstrb;
        end
      end
      WRESP:   bvalid = 1'b1;
      RD:      if (rd_issue) sram_cen_n_o = rd_oor;
      default: ;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rr_q     <= 1'b0;
      bid_q    <= '0;
      rid_q    <= '0;
      wr_err_q <= 1'b0;
      credit_q <= '0;
      pipe_q   <= '0;
    end else begin
      if ((state_q == IDLE) && awvalid && arvalid) rr_q <= ~rr_q;
      if (grant_wr) begin
        bid_q    <= awid;
        wr_err_q <= 1'b0;
      end else if (w_hs && wr_oor) begin
        wr_err_q <= 1'b1;
      end
      if (grant_rd) rid_q <= arid;
      case ({rd_issue, r_hs})
        2'b10:   credit_q <= credit_q + CRW'(1);
        2'b01:   credit_q <= credit_q - CRW'(1);
        default: ;
      endcase
      pipe_q[0] <= rd_meta_t'{vld: rd_issue, id: rid_q, last: rd_last, err: rd_oor};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out = pipe_q[RD_LAT-1];

  always_comb begin
    push_beat.id   = pipe_out.id;
    push_beat.data = pipe_out.err ? {DATA_WIDTH{1'b0}} : sram_rdata_i;
    push_beat.resp = pipe_out.err ? RESP_SLVERR : RESP_OKAY;
    push_beat.last = pipe_out.last;
  end

  sync_fifo #(.WIDTH($bits(r_beat_t)), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk(aclk_i), .rst_n(aresetn_i), .push(pipe_out.vld), .push_data(push_beat),
    .pop(r_hs), .pop_data(pop_beat), .empty(fifo_empty)
  );

  assign rvalid       = !fifo_empty;
  assign r_out        = rvalid ? pop_beat : '0;
  assign rid          = r_out.id;
  assign rdata        = r_out.data;
  assign rresp        = r_out.resp;
  assign rlast        = r_out.last;
  assign bid          = bid_q;
  assign bresp        = wr_err_q ? RESP_SLVERR : RESP_OKAY;
  assign sram_wdata_o = wdata;
endmodule

// File: tb/tb_axi4_sram_ctrl_v2.sv
// Directed bench: 32-bit bus, 16-word SRAM, two-cycle SRAM read latency.
module tb_axi4_sram_ctrl_v2;
  localparam int RDL = 2;

  logic        aclk = 1'b0, aresetn;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, sram_wdata, sram_rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb, sram_bm_n, sram_addr;
  logic        sram_cen_n, sram_wen_n;

  axi4_sram_ctrl_v2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(16),
                      .RD_LAT(RDL)) dut (
    .aclk_i(aclk), .aresetn_i(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_cen_n_o(sram_cen_n), .sram_wen_n_o(sram_wen_n), .sram_bm_n_o(sram_bm_n),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always #5 aclk = ~aclk;

  // SRAM macro model plus monitors of the SRAM port and the R channel.
  logic [31:0] mem [16];
  logic [31:0] sp [RDL];
  logic        mem_init_done = 1'b0;
  int          w_count = 0, r_hs_count = 0;
  logic [3:0]  w_addr, w_bm;
  logic [31:0] w_data;
  logic [3:0]  rd_addrs [$];

  always @(posedge aclk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1111_1111 * 32'(i);
      mem_init_done <= 1'b1;
    end else if (!sram_cen_n && !sram_wen_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_bm_n[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    if (!sram_cen_n && !sram_wen_n) begin
      w_count <= w_count + 1;
      w_addr  <= sram_addr;
      w_bm    <= sram_bm_n;
      w_data  <= sram_wdata;
    end
    if (!sram_cen_n && sram_wen_n) begin
      sp[0] <= mem[sram_addr];
      rd_addrs.push_back(sram_addr);
    end
    for (int i = 1; i < RDL; i++) sp[i] <= sp[i-1];
    if (rvalid && rready) r_hs_count <= r_hs_count + 1;
  end
  assign sram_rdata = sp[RDL-1];

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    if (w == 4) return 32'h44BB_44DD;  // preload 0x44444444 patched by strobes 0101
    return 32'h1111_1111 * 32'(w);
  endfunction

  logic [31:0] beat_data [16];
  logic [3:0]  beat_id   [16];
  logic [1:0]  beat_resp [16];
  logic        beat_last [16];
  int          beat_t    [16];
  int          nbeats, rd_base, issued_snap;

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall);
    int t;
    nbeats  = 0;
    rd_base = rd_addrs.size();
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    rready = (stall == 0);
    #1 check("arready", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    t = 1;
    while (nbeats <= int'(len) && t < 60) begin
      rready = (t > stall);
      if (t == stall) issued_snap = rd_addrs.size() - rd_base;
      if (rvalid && rready) begin
        beat_data[nbeats] = rdata; beat_id[nbeats] = rid; beat_resp[nbeats] = rresp;
        beat_last[nbeats] = rlast; beat_t[nbeats] = t;
        nbeats++;
      end
      @(negedge aclk);
      t++;
    end
    rready = 1'b0;
    check("rd_beat_count", nbeats, int'(len) + 1);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] strb, input logic [31:0] data, output logic [1:0] resp);
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    #1 check("awready", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    check("wready_after_aw", wready, 1);
    for (int b = 0; b <= int'(len); b++) begin
      wdata = data + 32'(b); wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_after_wlast", bvalid, 1);
    check("bid", bid, id);
    resp = bresp;
    @(negedge aclk);
    check("bvalid_hold", bvalid, 1);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_clear", bvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp, grant;
    int         base;
    logic [7:0] lasts;
    logic [3:0] wrap_exp [4];
    wrap_exp = '{4'd2, 4'd3, 4'd0, 4'd1};
    {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
    {awid, awaddr, awlen, awsize, awburst, wdata, wstrb} = '0;
    {arid, araddr, arlen, arsize, arburst} = '0;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_handshakes", {awready, arready, wready, bvalid, rvalid}, 5'b0);
    check("reset_sram_ctl", {sram_cen_n, sram_wen_n, sram_bm_n}, 6'h3F);
    check("reset_resp", {bid, rid, bresp, rresp, rlast}, 13'b0);
    check("reset_rdata", rdata, 0);
    aresetn = 1'b1;

    // Single masked write at byte 0x10.
    base = w_count;
    write_burst(4'h3, 32'h10, 8'd0, 4'b0101, 32'hAABB_CCDD, resp);
    check("wr_bresp", resp, 2'b00);
    check("wr_count", w_count - base, 1);
    check("wr_word_addr", w_addr, 4);
    check("wr_bm_n", w_bm, 4'b1010);
    check("wr_data", w_data, 32'hAABB_CCDD);

    // INCR read, len 7, full rate.
    read_burst(4'h5, 32'h0, 8'd7, 2'b01, 0);
    check("incr_first_rvalid", beat_t[0], 4);
    check("incr_last_beat_time", beat_t[7], 11);
    for (int k = 0; k < 8; k++) lasts[k] = beat_last[k];
    check("incr_rlast_map", lasts, 8'h80);
    for (int k = 0; k < 8; k++) begin
      check("incr_data", beat_data[k], exp_word(k));
      check("incr_rid", beat_id[k], 4'h5);
    end

    // Same read with R stalled for 10 cycles.
    read_burst(4'h6, 32'h0, 8'd7, 2'b01, 10);
    check("bp_issued_while_stalled", issued_snap, 4);
    check("bp_total_issued", rd_addrs.size() - rd_base, 8);
    for (int k = 0; k < 8; k++) check("bp_data", beat_data[k], exp_word(k));
    check("bp_rlast", beat_last[7], 1);

    // WRAP len 3 from 0x08.
    read_burst(4'h2, 32'h08, 8'd3, 2'b10, 0);
    check("wrap_issued", rd_addrs.size() - rd_base, 4);
    for (int k = 0; k < 4; k++) begin
      check("wrap_word_addr", rd_addrs[rd_base + k], wrap_exp[k]);
      check("wrap_data", beat_data[k], exp_word(int'(wrap_exp[k])));
    end

    // Out-of-range: words 14..17 of a 16-word SRAM.
    read_burst(4'h7, 32'h38, 8'd3, 2'b01, 0);
    check("oor_sram_reads", rd_addrs.size() - rd_base, 2);
    check("oor_resp", {beat_resp[0], beat_resp[1], beat_resp[2], beat_resp[3]}, 8'b00_00_10_10);
    check("oor_data0", beat_data[0], 32'hEEEE_EEEE);
    check("oor_data1", beat_data[1], 32'hFFFF_FFFF);
    check("oor_data2", beat_data[2], 32'h0);
    check("oor_data3", beat_data[3], 32'h0);
    base = w_count;
    write_burst(4'h1, 32'h38, 8'd3, 4'hF, 32'h1234_5678, resp);
    check("oor_bresp", resp, 2'b10);
    check("oor_sram_writes", w_count - base, 2);

    // Simultaneous AW/AR from reset: grants must alternate W,R,W,R.
    @(negedge aclk); aresetn = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    awid = 4'h1; awaddr = 32'h20; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    arid = 4'h2; araddr = 32'h24; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    rready = 1'b1;
    base = r_hs_count;
    @(negedge aclk);
    for (int r = 0; r < 4; r++) begin
      awvalid = 1'b1; arvalid = 1'b1;
      #1 grant = {awready, arready};
      check("arb_grant", grant, (r % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge aclk);
      if (grant == 2'b10) begin
        awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1; wstrb = 4'hF; wdata = 32'h5A5A_0000 + 32'(r);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
      end else begin
        arvalid = 1'b0;
        @(negedge aclk);
      end
    end
    awvalid = 1'b0; arvalid = 1'b0;
    repeat (10) @(negedge aclk);
    check("arb_read_beats", r_hs_count - base, 2);
    rready = 1'b0;

    // Reset in the middle of a stalled read: nothing may come out afterwards.
    @(negedge aclk);
    arid = 4'h9; araddr = 32'h0; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    repeat (8) @(negedge aclk);
    check("mid_read_pending", rvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_handshakes", {awready, arready, wready, bvalid, rvalid}, 5'b0);
    check("rst_mid_sram_ctl", {sram_cen_n, sram_wen_n, sram_bm_n}, 6'h3F);
    check("rst_mid_r_fields", {rid, rresp, rlast, rdata}, 39'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    rready = 1'b1;
    base = r_hs_count;
    repeat (20) @(negedge aclk);
    check("no_stale_r_beats", r_hs_count - base, 0);
    check("no_stale_rvalid", rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
